// File: rtl/bank_fill_sched.sv
// bank_fill_sched: sequences an upstream byte stream into NUM_BANKS single-port
// RAM banks of BANK_DEPTH bytes each, and tracks per-bank full flags.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   load_en, flush            loading enable (level), synchronous pointer/flag clear
//   in_valid/in_data/in_ready upstream byte handshake (in_ready depends only on state and flush)
//   rel_valid/rel_bank        consumer releases a full bank
//   ram_wr_en/ram_address/ram_select/ram_data  registered RAM write port
//   bank_full, full_count     per-bank full flags and their population count
//   bank_done/bank_done_idx   one-cycle pulse when a bank completes
//   rel_err                   one-cycle pulse when a non-full bank is released

// Per-bank full flag. full_n is exported so the scheduler can look ahead at the
// post-edge flag of the bank it is about to write.
module bank_flag (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic set,
    input  logic clr,
    output logic full,
    output logic full_n
);
    assign full_n = flush ? 1'b0 : (set | (full & ~clr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) full <= 1'b0;
        else     full <= full_n;
    end
endmodule

module bank_fill_sched #(
    parameter int NUM_BANKS  = 16,
    parameter int SEL_W      = 4,
    parameter int BANK_DEPTH = 940,
    parameter int ADDR_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    input  logic                 rel_valid,
    input  logic [SEL_W-1:0]     rel_bank,
    output logic                 ram_wr_en,
    output logic [ADDR_W-1:0]    ram_address,
    output logic [SEL_W-1:0]     ram_select,
    output logic [7:0]           ram_data,
    output logic [NUM_BANKS-1:0] bank_full,
    output logic                 bank_done,
    output logic [SEL_W-1:0]     bank_done_idx,
    output logic [SEL_W:0]       full_count,
    output logic                 rel_err
);
    localparam int CNT_W = SEL_W + 1;

    typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

    state_t               state, state_n;
    logic [SEL_W-1:0]     wr_sel, sel_n;
    logic [ADDR_W-1:0]    wr_addr, addr_n;
    logic                 accept, last, done_n, rel_hit, rel_miss;
    logic [NUM_BANKS-1:0] set_vec, clr_vec, full_n;

    // flush blocks acceptance in its own cycle; no path from in_valid.
    assign in_ready = (state == FILL) && !flush;
    assign accept   = in_valid && in_ready;
    assign last     = (wr_addr == ADDR_W'(BANK_DEPTH - 1));
    assign done_n   = accept && last;

    // A release of a non-full bank is an error; a completing bank is still
    // non-full this cycle, so releasing it together with completion errors too.
    assign rel_hit  = rel_valid && bank_full[rel_bank] && !flush;
    assign rel_miss = rel_valid && !bank_full[rel_bank] && !flush;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        assign set_vec[i] = done_n && (wr_sel == SEL_W'(i));
        assign clr_vec[i] = rel_hit && (rel_bank == SEL_W'(i));
        bank_flag u_flag (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush),
            .set    (set_vec[i]),
            .clr    (clr_vec[i]),
            .full   (bank_full[i]),
            .full_n (full_n[i])
        );
    end

    // Next pointers and next state. The state looks at the post-edge flag of
    // the post-edge write bank, so a release or a wrap is reflected in
    // in_ready exactly one cycle later.
    always_comb begin
        sel_n  = wr_sel;
        addr_n = wr_addr;
        if (flush) begin
            sel_n  = '0;
            addr_n = '0;
        end else if (accept) begin
            if (last) begin
                addr_n = '0;
                sel_n  = wr_sel + SEL_W'(1); // power-of-two bank count wraps naturally
            end else begin
                addr_n = wr_addr + ADDR_W'(1);
            end
        end
        if (!load_en)            state_n = IDLE;
        else if (full_n[sel_n])  state_n = STALL;
        else                     state_n = FILL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wr_sel        <= '0;
            wr_addr       <= '0;
            ram_wr_en     <= 1'b0;
            ram_address   <= '0;
            ram_select    <= '0;
            ram_data      <= '0;
            bank_done     <= 1'b0;
            bank_done_idx <= '0;
            full_count    <= '0;
            rel_err       <= 1'b0;
        end else begin
            state     <= state_n;
            wr_sel    <= sel_n;
            wr_addr   <= addr_n;
            ram_wr_en <= accept;
            if (accept) begin
                ram_address <= wr_addr;
                ram_select  <= wr_sel;
                ram_data    <= in_data;
            end
            bank_done <= done_n;
            if (done_n) bank_done_idx <= wr_sel;
            rel_err <= rel_miss;
            if (flush) full_count <= '0;
            else       full_count <= full_count + CNT_W'(done_n) - CNT_W'(rel_hit);
        end
    end
endmodule

// File: tb/tb_bank_fill_sched.sv
module tb_bank_fill_sched;
    localparam int NB = 16;
    localparam int SW = 4;
    localparam int D  = 940;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst, load_en, flush, in_valid, in_ready, rel_valid;
    logic [7:0]    in_data, ram_data;
    logic [SW-1:0] rel_bank, ram_select, bank_done_idx;
    logic          ram_wr_en, bank_done, rel_err;
    logic [AW-1:0] ram_address;
    logic [NB-1:0] bank_full;
    logic [SW:0]   full_count;

    bank_fill_sched #(.NUM_BANKS(NB), .SEL_W(SW), .BANK_DEPTH(D), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rel_valid(rel_valid), .rel_bank(rel_bank),
        .ram_wr_en(ram_wr_en), .ram_address(ram_address), .ram_select(ram_select),
        .ram_data(ram_data), .bank_full(bank_full), .bank_done(bank_done),
        .bank_done_idx(bank_done_idx), .full_count(full_count), .rel_err(rel_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t           wq[$];
    logic [SW-1:0] dq[$];
    int            vectors = 0;
    int            miscompares = 0;

    // Reference model: flags as a bit set, write position as plain integers,
    // readiness is "enabled and current bank not full" as of the last edge.
    logic [NB-1:0] m_full;
    int            m_sel, m_addr;
    bit            m_rdy;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every RAM write and every completion pulse must match the next
    // expected entry.
    always @(negedge clk) begin : monitor
        wr_t           e;
        logic [SW-1:0] di;
        if (!rst) begin
            if (ram_wr_en) begin
                if (wq.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    e = wq.pop_front();
                    chk("ram_select", ram_select, e.sel);
                    chk("ram_address", ram_address, e.addr);
                    chk("ram_data", ram_data, e.data);
                end
            end
            if (bank_done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    di = dq.pop_front();
                    chk("bank_done_idx", bank_done_idx, di);
                end
            end
        end
    end

    // Called at a falling edge with inputs already driven; advances one cycle.
    task automatic step();
        logic [NB-1:0] clr;
        bit acc, e_err;
        #1;
        chk("in_ready", in_ready, m_rdy && !flush);
        acc   = in_valid && m_rdy && !flush;
        e_err = 0;
        if (flush) begin
            m_full = '0; m_sel = 0; m_addr = 0;
        end else begin
            clr = '0;
            if (rel_valid) begin
                if (m_full[rel_bank]) clr[rel_bank] = 1'b1;
                else                  e_err = 1;
            end
            if (acc) begin
                wq.push_back(wr_t'{sel: SW'(m_sel), addr: AW'(m_addr), data: in_data});
                if (m_addr == D - 1) begin
                    dq.push_back(SW'(m_sel));
                    m_full[m_sel] = 1'b1;
                    m_addr = 0;
                    m_sel  = (m_sel + 1) % NB;
                end else begin
                    m_addr++;
                end
            end
            m_full &= ~clr;
        end
        m_rdy = load_en && !m_full[m_sel];
        @(negedge clk);
        chk("bank_full", bank_full, m_full);
        chk("full_count", full_count, $countones(m_full));
        chk("rel_err", rel_err, e_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, ram_wr_en, 0);
        chk({tag, "_address"}, ram_address, 0);
        chk({tag, "_select"}, ram_select, 0);
        chk({tag, "_data"}, ram_data, 0);
        chk({tag, "_full"}, bank_full, 0);
        chk({tag, "_done"}, bank_done, 0);
        chk({tag, "_done_idx"}, bank_done_idx, 0);
        chk({tag, "_count"}, full_count, 0);
        chk({tag, "_rel_err"}, rel_err, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic model_reset();
        m_full = '0; m_sel = 0; m_addr = 0; m_rdy = 0;
        wq.delete(); dq.delete();
    endtask

    task automatic rand_byte(input int pct);
        in_valid = ($urandom_range(0, 99) < pct);
        in_data  = 8'($urandom);
    endtask

    initial begin
        bit dropped;
        rst = 1; load_en = 0; flush = 0; in_valid = 0; in_data = '0;
        rel_valid = 0; rel_bank = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 0;

        // Bank 0 with continuous valid: addresses 0..939, then bank 1.
        load_en = 1;
        for (int n = 0; n < 5000 && m_sel != 1; n++) begin
            rand_byte(100); step();
        end
        chk("bank0_full", bank_full, 16'h0001);
        chk("bank0_count", full_count, 1);
        in_valid = 1; step(); // first byte of bank 1, checked by the monitor

        // Fill everything without releases, stall, then release bank 0.
        for (int n = 0; n < 40000 && m_full != 16'hFFFF; n++) begin
            rand_byte(75); step();
        end
        in_valid = 1;
        repeat (5) step();
        chk("all_full", bank_full, 16'hFFFF);
        chk("stall_ready", in_ready, 0);
        rel_valid = 1; rel_bank = 0; step();
        rel_valid = 0;
        chk("rel_ready", in_ready, 1);
        step(); // bank 0, address 0
        repeat (3) step();

        // Flush everything, then release a non-full bank.
        flush = 1; step(); flush = 0;
        chk("flush_full", bank_full, 0);
        in_valid = 0; rel_valid = 1; rel_bank = 5; step();
        rel_valid = 0;

        // Fill banks 0..3: drop load_en at bank 2 address 500, and release
        // bank 0 in the cycle bank 3 completes.
        dropped = 0;
        for (int n = 0; n < 10000 && m_sel != 4; n++) begin
            rand_byte(75); rel_valid = 0;
            if (!dropped && m_sel == 2 && m_addr == 500 && m_rdy) begin
                dropped = 1;
                in_valid = 1; load_en = 0; step();
                repeat (9) begin rand_byte(50); step(); end
                load_en = 1;
            end else if (m_sel == 3 && m_addr == D - 1 && m_rdy) begin
                in_valid = 1; rel_valid = 1; rel_bank = 0; step();
                rel_valid = 0;
                chk("cross_full", bank_full, 16'h000E);
                chk("cross_count", full_count, 3);
            end else begin
                step();
            end
        end

        // Run to bank 7 address 200, then flush mid-bank.
        for (int n = 0; n < 10000 && !(m_sel == 7 && m_addr == 200); n++) begin
            rand_byte(80); step();
        end
        in_valid = 1; flush = 1; step(); flush = 0;
        chk("flush2_full", bank_full, 0);
        chk("flush2_count", full_count, 0);
        repeat (30) begin rand_byte(100); step(); end

        // Asynchronous reset between edges, mid-bank.
        #2 rst = 1;
        #1 chk_all_zero("async_rst");
        model_reset();
        in_valid = 0; load_en = 0;
        @(negedge clk); @(negedge clk);
        rst = 0;

        // Randomized mix of enable, releases and occasional flushes.
        for (int n = 0; n < 4000; n++) begin
            load_en   = ($urandom_range(0, 19) != 0);
            rand_byte(75);
            rel_valid = ($urandom_range(0, 9) == 0);
            rel_bank  = SW'($urandom_range(0, NB - 1));
            flush     = ($urandom_range(0, 499) == 0);
            step();
        end

        rel_valid = 0; flush = 0; in_valid = 0; load_en = 0;
        repeat (2) step();
        chk("writes_pending", wq.size(), 0);
        chk("dones_pending", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
